// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo
//   Single-clock first-word-fall-through FIFO. The head word is always
//   presented on dout; rd_en acknowledges (pops) it. Occupancy is exported
//   as rd_data_count, and reset-busy flags hold off traffic for a few
//   cycles after reset releases.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   din, wr_en     write data / push request
//   dout, rd_en    head word (FWFT) / pop acknowledge
//   full, empty    occupancy == DEPTH / occupancy == 0
//   almost_full    occupancy == DEPTH-1
//   almost_empty   occupancy == 1
//   rd_data_count  occupancy, 0..DEPTH
//   overflow       pulse: previous cycle's write was rejected (full)
//   underflow      pulse: previous cycle's read was rejected (empty)
//   wr_rst_busy    write side in reset, writes ignored
//   rd_rst_busy    read side in reset, reads ignored
module sync_fwft_fifo #(
  parameter int                DATA_W           = 8,
  parameter int                DEPTH            = 32,
  parameter int                COUNT_W          = $clog2(DEPTH) + 1,
  parameter logic [DATA_W-1:0] DOUT_RESET_VALUE = '0,
  parameter int                RST_BUSY_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  din,
  input  logic               wr_en,
  output logic [DATA_W-1:0]  dout,
  input  logic               rd_en,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [COUNT_W-1:0] rd_data_count,
  output logic               overflow,
  output logic               underflow,
  output logic               wr_rst_busy,
  output logic               rd_rst_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(RST_BUSY_CYCLES + 2);
  localparam logic [BW-1:0]      BUSY_END   = BW'(RST_BUSY_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_FULL   = COUNT_W'(DEPTH);
  localparam logic [COUNT_W-1:0] CNT_AFULL  = COUNT_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] CNT_AEMPTY = COUNT_W'(1);

  typedef enum logic {
    ST_BUSY,
    ST_RUN
  } rst_state_t;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_nxt;
  logic [BW-1:0]      busy_cnt;
  rst_state_t         state;
  logic               busy;
  logic               wr_ok;
  logic               rd_ok;

  assign busy = (state == ST_BUSY);

  // Full/empty are judged on the registered count, so a pointer wrap can
  // never make a full FIFO look empty or vice versa.
  always_comb begin
    wr_ok     = wr_en && !full && !busy;
    rd_ok     = rd_en && !empty && !busy;
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage is not reset; reset discards contents by clearing pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_BUSY;
      busy_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      // Busy holds for RST_BUSY_CYCLES edges with rst sampled low.
      if (state == ST_BUSY) begin
        busy_cnt <= busy_cnt + 1'b1;
        if (busy_cnt + 1'b1 >= BUSY_END) begin
          state <= ST_RUN;
        end
      end
      overflow  <= wr_en && full && !busy;
      underflow <= rd_en && empty && !busy;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CNT_FULL);
      almost_full  <= (count_nxt == CNT_AFULL);
      almost_empty <= (count_nxt == CNT_AEMPTY);
    end
  end

  // empty is registered, so a word written at edge N is both in memory and
  // unmasked in the cycle after edge N.
  assign dout          = empty ? DOUT_RESET_VALUE : mem[rd_ptr];
  assign rd_data_count = count;
  assign wr_rst_busy   = busy;
  assign rd_rst_busy   = busy;

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Self-checking bench for sync_fwft_fifo (DATA_W=8, DEPTH=32).
module tb_sync_fwft_fifo;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 32;
  localparam int COUNT_W = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [DATA_W-1:0]  din;
  logic               wr_en;
  logic [DATA_W-1:0]  dout;
  logic               rd_en;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [COUNT_W-1:0] rd_data_count;
  logic               overflow;
  logic               underflow;
  logic               wr_rst_busy;
  logic               rd_rst_busy;

  always #5 clk = ~clk;

  sync_fwft_fifo #(
    .DATA_W          (DATA_W),
    .DEPTH           (DEPTH),
    .COUNT_W         (COUNT_W),
    .DOUT_RESET_VALUE(8'h00),
    .RST_BUSY_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .dout         (dout),
    .rd_en        (rd_en),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .rd_data_count(rd_data_count),
    .overflow     (overflow),
    .underflow    (underflow),
    .wr_rst_busy  (wr_rst_busy),
    .rd_rst_busy  (rd_rst_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: scoreboard queue holds the words expected on dout.
  logic [DATA_W-1:0] sb[$];
  int m_cnt  = 0;
  bit m_busy = 1'b1;
  int m_bcnt = 0;
  bit m_ovf  = 1'b0;
  bit m_unf  = 1'b0;

  function automatic logic [DATA_W-1:0] exp_head();
    if (sb.size() > 0) return sb[0];
    return 8'h00;
  endfunction

  // Drive one cycle of stimulus, advance past the edge, update the model.
  task automatic step(input bit r_st, input bit w, input logic [DATA_W-1:0] d, input bit r);
    bit w_ok;
    bit r_ok;
    rst   = r_st;
    wr_en = w;
    din   = d;
    rd_en = r;
    w_ok  = !r_st && w && !m_busy && (m_cnt < DEPTH);
    r_ok  = !r_st && r && !m_busy && (m_cnt > 0);
    @(posedge clk);
    #1;
    if (r_st) begin
      sb.delete();
      m_busy = 1'b1;
      m_bcnt = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_ovf = w && !m_busy && (m_cnt == DEPTH);
      m_unf = r && !m_busy && (m_cnt == 0);
      if (r_ok) void'(sb.pop_front());
      if (w_ok) sb.push_back(d);
      if (m_busy) begin
        m_bcnt++;
        if (m_bcnt >= 2) m_busy = 1'b0;
      end
    end
    m_cnt = sb.size();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h11, 1'b1);
      n_cmp++; if (wr_rst_busy !== 1'b1 || rd_rst_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b%b exp 11", wr_rst_busy, rd_rst_busy); end
      n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", empty, full); end
      n_cmp++; if (dout !== 8'h00 || rd_data_count !== 6'd0) begin n_err++; $display("FAIL reset_data got dout=%h cnt=%0d exp 00/0", dout, rd_data_count); end
    end
    step(1'b0, 1'b1, 8'h22, 1'b1);
    n_cmp++; if (wr_rst_busy !== 1'b1 || rd_rst_busy !== 1'b1) begin n_err++; $display("FAIL busy_hold1 got %b%b exp 11", wr_rst_busy, rd_rst_busy); end
    n_cmp++; if (rd_data_count !== 6'd0 || underflow !== 1'b0) begin n_err++; $display("FAIL busy_drop1 got cnt=%0d unf=%b exp 0/0", rd_data_count, underflow); end
    step(1'b0, 1'b1, 8'h33, 1'b0);
    n_cmp++; if (wr_rst_busy !== 1'b0 || rd_rst_busy !== 1'b0) begin n_err++; $display("FAIL busy_release got %b%b exp 00", wr_rst_busy, rd_rst_busy); end
    n_cmp++; if (rd_data_count !== 6'd0 || empty !== 1'b1) begin n_err++; $display("FAIL busy_drop2 got cnt=%0d e=%b exp 0/1", rd_data_count, empty); end
    n_cmp++; if (almost_full !== 1'b0 || almost_empty !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_misc got af=%b ae=%b ovf=%b exp 000", almost_full, almost_empty, overflow); end
  endtask

  task automatic test_single();
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    n_cmp++; if (dout !== 8'hA5 || dout !== exp_head()) begin n_err++; $display("FAIL single_dout got %h exp a5", dout); end
    n_cmp++; if (empty !== 1'b0 || almost_empty !== 1'b1 || rd_data_count !== 6'd1) begin n_err++; $display("FAIL single_flags got e=%b ae=%b cnt=%0d exp 0/1/1", empty, almost_empty, rd_data_count); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (dout !== 8'h00 || empty !== 1'b1 || rd_data_count !== 6'd0) begin n_err++; $display("FAIL single_pop got dout=%h e=%b cnt=%0d exp 00/1/0", dout, empty, rd_data_count); end
    n_cmp++; if (almost_empty !== 1'b0) begin n_err++; $display("FAIL single_ae got %b exp 0", almost_empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, DATA_W'(i), 1'b0);
      n_cmp++; if (rd_data_count !== COUNT_W'(m_cnt) || m_cnt != i + 1) begin n_err++; $display("FAIL fill_cnt[%0d] got %0d exp %0d", i, rd_data_count, i + 1); end
      n_cmp++; if (full !== (i == DEPTH - 1) || almost_full !== (i == DEPTH - 2)) begin n_err++; $display("FAIL fill_flags[%0d] got f=%b af=%b", i, full, almost_full); end
      n_cmp++; if (dout !== 8'h00 || empty !== 1'b0 || almost_empty !== (i == 0)) begin n_err++; $display("FAIL fill_head[%0d] got dout=%h e=%b ae=%b", i, dout, empty, almost_empty); end
    end
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    n_cmp++; if (overflow !== 1'b1 || overflow !== m_ovf) begin n_err++; $display("FAIL ovf_pulse got %b exp 1", overflow); end
    n_cmp++; if (rd_data_count !== 6'd32 || full !== 1'b1) begin n_err++; $display("FAIL ovf_cnt got cnt=%0d f=%b exp 32/1", rd_data_count, full); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    // Write while full with an accepted read: write is dropped, read happens.
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    n_cmp++; if (overflow !== 1'b1 || rd_data_count !== 6'd31 || full !== 1'b0 || almost_full !== 1'b1) begin n_err++; $display("FAIL full_rw got ovf=%b cnt=%0d f=%b af=%b exp 1/31/0/1", overflow, rd_data_count, full, almost_full); end
    for (int i = 1; i < DEPTH; i++) begin
      n_cmp++; if (dout !== exp_head() || dout !== DATA_W'(i)) begin n_err++; $display("FAIL drain_data[%0d] got %h exp %h", i, dout, DATA_W'(i)); end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (rd_data_count !== COUNT_W'(DEPTH - 1 - i)) begin n_err++; $display("FAIL drain_cnt[%0d] got %0d exp %0d", i, rd_data_count, DEPTH - 1 - i); end
    end
    n_cmp++; if (empty !== 1'b1 || dout !== 8'h00 || underflow !== 1'b0) begin n_err++; $display("FAIL drain_end got e=%b dout=%h unf=%b exp 1/00/0", empty, dout, underflow); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (underflow !== 1'b1 || underflow !== m_unf || rd_data_count !== 6'd0) begin n_err++; $display("FAIL unf_pulse got unf=%b cnt=%0d exp 1/0", underflow, rd_data_count); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL unf_clear got %b exp 0", underflow); end
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    n_cmp++; if (underflow !== 1'b1 || rd_data_count !== 6'd1 || dout !== 8'h5A) begin n_err++; $display("FAIL unf_rw got unf=%b cnt=%0d dout=%h exp 1/1/5a", underflow, rd_data_count, dout); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (underflow !== 1'b0 || rd_data_count !== 6'd0 || empty !== 1'b1) begin n_err++; $display("FAIL unf_pop got unf=%b cnt=%0d e=%b exp 0/0/1", underflow, rd_data_count, empty); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DATA_W'(i), 1'b0);
    n_cmp++; if (rd_data_count !== 6'd5) begin n_err++; $display("FAIL sim_prefill got %0d exp 5", rd_data_count); end
    for (int i = 0; i < 100; i++) begin
      n_cmp++; if (dout !== exp_head() || dout !== DATA_W'(i)) begin n_err++; $display("FAIL sim_data[%0d] got %h exp %h", i, dout, DATA_W'(i)); end
      step(1'b0, 1'b1, DATA_W'(i + 5), 1'b1);
      n_cmp++; if (rd_data_count !== 6'd5 || full !== 1'b0 || empty !== 1'b0 || almost_empty !== 1'b0) begin n_err++; $display("FAIL sim_cnt[%0d] got cnt=%0d f=%b e=%b ae=%b exp 5/0/0/0", i, rd_data_count, full, empty, almost_empty); end
    end
    for (int i = 100; i < 105; i++) begin
      n_cmp++; if (dout !== DATA_W'(i)) begin n_err++; $display("FAIL sim_tail[%0d] got %h exp %h", i, dout, DATA_W'(i)); end
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    n_cmp++; if (empty !== 1'b1 || rd_data_count !== 6'd0) begin n_err++; $display("FAIL sim_end got e=%b cnt=%0d exp 1/0", empty, rd_data_count); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, DATA_W'(8'h80 + i), 1'b0);
    n_cmp++; if (rd_data_count !== 6'd10 || dout !== 8'h80) begin n_err++; $display("FAIL mid_pre got cnt=%0d dout=%h exp 10/80", rd_data_count, dout); end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (rd_data_count !== 6'd0 || empty !== 1'b1 || dout !== 8'h00) begin n_err++; $display("FAIL mid_rst got cnt=%0d e=%b dout=%h exp 0/1/00", rd_data_count, empty, dout); end
    n_cmp++; if (wr_rst_busy !== 1'b1 || rd_rst_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b%b exp 11", wr_rst_busy, rd_rst_busy); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (wr_rst_busy !== 1'b0 || m_busy !== 1'b0) begin n_err++; $display("FAIL mid_release got %b exp 0", wr_rst_busy); end
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    n_cmp++; if (dout !== 8'h3C || dout !== exp_head() || rd_data_count !== 6'd1) begin n_err++; $display("FAIL mid_write got dout=%h cnt=%0d exp 3c/1", dout, rd_data_count); end
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_underflow();
    test_simultaneous();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fwft_fifo.md
Name: sync_fwft_fifo

Overview:
Single-clock first-word-fall-through (FWFT) FIFO with a read data count and reset-busy flags. It is the storage primitive behind the team's single-clock FIFO wrapper, which maps its tail/head/push/pop interface onto din/dout/wr_en/rd_en and exports rd_data_count as data_count. The head word is always presented on dout without a read request, and rd_en acknowledges (pops) it.

Parameters:
DATA_W, 8, width of din/dout in bits (wrapper passes the bit width of its item type).
DEPTH, 32, number of storage words; power of two, 16 or more; all DEPTH words usable.
COUNT_W, $clog2(DEPTH)+1, width of rd_data_count; must hold 0..DEPTH.
DOUT_RESET_VALUE, 0, value driven on dout during reset and whenever empty=1.
RST_BUSY_CYCLES, 2, cycles the busy flags stay high after rst deasserts.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
din  in  DATA_W  write data.
wr_en  in  1  write request (push).
dout  out  DATA_W  head word (FWFT).
rd_en  in  1  read acknowledge (pop).
full  out  1  high when occupancy equals DEPTH.
empty  out  1  high when occupancy is 0.
almost_full  out  1  high when occupancy equals DEPTH-1.
almost_empty  out  1  high when occupancy equals 1.
rd_data_count  out  COUNT_W  current occupancy, 0..DEPTH.
overflow  out  1  registered pulse: the previous cycle's write was rejected.
underflow  out  1  registered pulse: the previous cycle's read was rejected.
wr_rst_busy  out  1  write side is in reset; writes are ignored.
rd_rst_busy  out  1  read side is in reset; reads are ignored.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers and count go to 0; empty=1, full=0, almost_* =0, overflow=underflow=0.
  - dout=DOUT_RESET_VALUE.
  - wr_rst_busy=rd_rst_busy=1.
  - Reset mid-operation discards all stored data.
- Busy flags: stay high while rst=1 and for RST_BUSY_CYCLES edges after rst is sampled low, then drop together. While busy, wr_en and rd_en are ignored and no overflow/underflow pulse is produced.
- Write accepted when wr_en=1, full=0 and not busy:
  - din is stored at the write pointer and the pointer increments modulo DEPTH.
  - wr_en with full=1 writes nothing (even with a simultaneous accepted read); overflow=1 on the next cycle.
- Read accepted when rd_en=1, empty=0 and not busy:
  - The read pointer increments modulo DEPTH.
  - rd_en with empty=1 does nothing (even with a simultaneous accepted write); underflow=1 on the next cycle.
- FWFT timing:
  - A word written at edge N makes empty=0 and appears on dout in the cycle following edge N (one-cycle latency).
  - After an accepted read at edge N, dout shows the next word in the cycle following edge N, or DOUT_RESET_VALUE if the FIFO is now empty.
  - Data leaves in write order.
- Count: rd_data_count = occupancy, registered and updated at the same edge as the flags. Per edge: +1 for an accepted write only, -1 for an accepted read only, unchanged if both or neither.
- Flags: full, empty, almost_full and almost_empty are registered and consistent with rd_data_count in every cycle.
- Wrap-around: pointers carry one extra bit, or a separate count is kept, so that full and empty are unambiguous after any number of wraps.
- Simultaneous accepted read and write at occupancy 1..DEPTH-1: occupancy is unchanged and the order is preserved.

Test Plan:
- Reset behaviour: assert rst 3 cycles, then release -> empty=1, full=0, dout=0, count=0; busy flags high during rst plus 2 cycles. A wr_en issued while busy is dropped (count stays 0).
- Single word: write 0xA5 -> next cycle empty=0, dout=0xA5, count=1, almost_empty=1. Then rd_en -> next cycle empty=1, dout=0, count=0.
- Fill and overflow (DEPTH=32): write 0..31 -> full=1, count=32, almost_full seen at 31. Write 0xFF -> overflow pulse for 1 cycle, count stays 32. Drain -> data 0..31 in order.
- Underflow: rd_en on an empty FIFO -> underflow pulse for 1 cycle, count stays 0. rd_en together with wr_en on empty -> count becomes 1, underflow=1.
- Simultaneous read and write: with count=5, hold wr_en and rd_en for 100 cycles with an incrementing din -> count stays 5 throughout, pointers wrap, and the output sequence is contiguous.
- Mid-operation reset: with 10 words stored, pulse rst -> count=0, empty=1, dout=0. After busy clears, write 0x3C -> dout=0x3C.
